// File: rtl/fea_pkg.sv
// rtl/fea_pkg.sv - shared types and width helpers for the vertical window buffer
package fea_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    // Rows above and below the window centre.
    function automatic int calc_half(input int lines);
        return (lines - 1) / 2;
    endfunction

    // Counter/address width for a range of n values, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_WIDTH = 8;
    localparam int DEF_LINES = 11;
    localparam int DEF_COL   = 376;
    localparam int DEF_ROW   = 240;
    localparam int DEF_HALF  = calc_half(DEF_LINES);
    localparam int DEF_ROW_W = cnt_w(DEF_ROW);
    localparam int DEF_COL_W = cnt_w(DEF_COL);

endpackage

// File: rtl/fea_window_buffer_if.sv
// rtl/fea_window_buffer_if.sv - pixel input and window output bundle
interface fea_window_buffer_if
    import fea_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LINES = DEF_LINES,
    parameter int COL   = DEF_COL,
    parameter int ROW   = DEF_ROW
);
    localparam int ROW_W = cnt_w(ROW);
    localparam int COL_W = cnt_w(COL);

    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       din;
    logic                   sof;
    logic                   out_valid;
    logic [LINES*WIDTH-1:0] taps;
    logic [ROW_W-1:0]       out_row;
    logic [COL_W-1:0]       out_col;
    logic                   out_sof;
    logic                   out_eof;

    modport master (
        output in_valid, din, sof,
        input  in_ready, out_valid, taps, out_row, out_col, out_sof, out_eof
    );

    modport slave (
        input  in_valid, din, sof,
        output in_ready, out_valid, taps, out_row, out_col, out_sof, out_eof
    );

endinterface

// File: rtl/fea_line_ram.sv
// rtl/fea_line_ram.sv - one line store, registered read, read-before-write
module fea_line_ram
    import fea_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_COL
) (
    input  logic                     clk,
    input  logic                     rd_en,
    input  logic [cnt_w(DEPTH)-1:0]  rd_addr,
    output logic [WIDTH-1:0]         rd_data,
    input  logic                     wr_en,
    input  logic [cnt_w(DEPTH)-1:0]  wr_addr,
    input  logic [WIDTH-1:0]         wr_data
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q, rd_data_d;

    // Read data only moves on a read strobe so it can feed the next line later.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    // Storage and read register; a same-address read returns the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fea_window_buffer.sv
// rtl/fea_window_buffer.sv - vertical LINES-tall window generator with border handling
module fea_window_buffer
    import fea_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int LINES  = DEF_LINES,
    parameter int COL    = DEF_COL,
    parameter int ROW    = DEF_ROW,
    parameter bit BORDER = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    fea_window_buffer_if.slave bus
);
    localparam int HALF  = calc_half(LINES);
    localparam int NMEM  = LINES - 1;
    localparam int ROW_W = cnt_w(ROW);
    localparam int COL_W = cnt_w(COL);
    localparam int RC_W  = cnt_w(ROW + HALF);  // input row also counts the flush rows
    localparam int IDX_W = cnt_w(LINES);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COL - 1);

    state_t              state_q, state_d;
    logic [RC_W-1:0]     row_q, row_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic                ready_q, ready_d;

    logic                s1_valid_q, s1_valid_d;
    logic                s1_wr_q, s1_wr_d;
    logic [ROW_W-1:0]    s1_row_q, s1_row_d;
    logic [COL_W-1:0]    s1_col_q, s1_col_d;
    logic [WIDTH-1:0]    s1_pix_q, s1_pix_d;

    logic                   out_valid_q, out_valid_d;
    logic                   out_sof_q, out_sof_d;
    logic                   out_eof_q, out_eof_d;
    logic [LINES*WIDTH-1:0] taps_q, taps_d;
    logic [ROW_W-1:0]       out_row_q, out_row_d;
    logic [COL_W-1:0]       out_col_q, out_col_d;

    logic                acc;
    logic                beat;
    logic                emit;
    logic [RC_W-1:0]     pos_row;
    logic [COL_W-1:0]    pos_col;
    logic [WIDTH-1:0]    wr_pix;

    logic [WIDTH-1:0]       rd_data [NMEM];
    logic [WIDTH-1:0]       wr_data [NMEM];
    logic [WIDTH-1:0]       raw [LINES];
    logic [LINES*WIDTH-1:0] win;

    assign acc          = bus.in_valid && ready_q;
    assign bus.in_ready = ready_q;

    // Frame sequencing: decides whether this cycle is a storage beat, which position
    // it carries and whether it completes a window.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        beat    = 1'b0;
        emit    = 1'b0;
        pos_row = row_q;
        pos_col = col_q;
        wr_pix  = bus.din;
        case (state_q)
            ST_IDLE, ST_FILL, ST_RUN: begin
                if (acc && (bus.sof || state_q != ST_IDLE)) begin
                    beat = 1'b1;
                    if (bus.sof) begin
                        pos_row = '0;
                        pos_col = '0;
                    end
                    if (bus.sof || state_q != ST_RUN) begin
                        if (pos_row == RC_W'(HALF - 1) && pos_col == COL_LAST) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_FILL;
                        end
                    end else begin
                        emit = 1'b1;
                        if (pos_row == RC_W'(ROW - 1) && pos_col == COL_LAST) begin
                            state_d = ST_FLUSH;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                beat   = 1'b1;
                emit   = 1'b1;
                wr_pix = '0;  // beyond the frame; padding hides whatever is shifted in
                if (pos_row == RC_W'(ROW + HALF - 1) && pos_col == COL_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (beat) begin
            if (pos_col == COL_LAST) begin
                col_d = '0;
                row_d = (pos_row == RC_W'(ROW + HALF - 1)) ? '0 : pos_row + RC_W'(1);
            end else begin
                col_d = pos_col + COL_W'(1);
                row_d = pos_row;
            end
        end
        ready_d = (state_d != ST_FLUSH);
    end

    // Beat capture alongside the line reads; also holds the delayed chain write.
    always_comb begin
        s1_valid_d = emit;
        s1_wr_d    = beat;
        s1_col_d   = beat ? pos_col : s1_col_q;
        s1_pix_d   = beat ? wr_pix : s1_pix_q;
        s1_row_d   = emit ? ROW_W'(pos_row - RC_W'(HALF)) : s1_row_q;
    end

    // Line chain: every line reads at the beat column, then each line takes the
    // old word of the line above one cycle later, once that word has been read.
    for (genvar k = 0; k < NMEM; k++) begin : g_line
        if (k == 0) begin : g_head
            assign wr_data[k] = s1_pix_q;
        end else begin : g_tail
            assign wr_data[k] = rd_data[k-1];
        end
        fea_line_ram #(
            .WIDTH (WIDTH),
            .DEPTH (COL)
        ) u_ram (
            .clk     (clk),
            .rd_en   (beat),
            .rd_addr (pos_col),
            .rd_data (rd_data[k]),
            .wr_en   (s1_wr_q),
            .wr_addr (s1_col_q),
            .wr_data (wr_data[k])
        );
    end

    // Raw column, oldest line at the top: slice i holds input row r-(LINES-1)+i.
    always_comb begin
        for (int i = 0; i < NMEM; i++) begin
            raw[i] = rd_data[NMEM-1-i];
        end
        raw[LINES-1] = s1_pix_q;
    end

    // Border handling: rows outside the frame take the edge row of the same column or 0.
    always_comb begin
        int               tr;
        logic [IDX_W-1:0] sel;
        tr  = 0;
        sel = '0;
        win = '0;
        for (int i = 0; i < LINES; i++) begin
            tr = int'(s1_row_q) - HALF + i;
            if (tr < 0) begin
                sel = IDX_W'(HALF - int'(s1_row_q));
                win[i*WIDTH +: WIDTH] = BORDER ? raw[sel] : '0;
            end else if (tr > ROW - 1) begin
                sel = IDX_W'(ROW - 1 - int'(s1_row_q) + HALF);
                win[i*WIDTH +: WIDTH] = BORDER ? raw[sel] : '0;
            end else begin
                win[i*WIDTH +: WIDTH] = raw[i];
            end
        end
    end

    // Output register; position and taps hold between windows, flags pulse.
    always_comb begin
        out_valid_d = s1_valid_q;
        out_sof_d   = s1_valid_q && s1_row_q == '0 && s1_col_q == '0;
        out_eof_d   = s1_valid_q && s1_row_q == ROW_W'(ROW - 1) && s1_col_q == COL_LAST;
        taps_d      = s1_valid_q ? win : taps_q;
        out_row_d   = s1_valid_q ? s1_row_q : out_row_q;
        out_col_d   = s1_valid_q ? s1_col_q : out_col_q;
    end

    // All control and output state, cleared immediately by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            ready_q     <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_wr_q     <= 1'b0;
            s1_row_q    <= '0;
            s1_col_q    <= '0;
            s1_pix_q    <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            taps_q      <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            ready_q     <= ready_d;
            s1_valid_q  <= s1_valid_d;
            s1_wr_q     <= s1_wr_d;
            s1_row_q    <= s1_row_d;
            s1_col_q    <= s1_col_d;
            s1_pix_q    <= s1_pix_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
            taps_q      <= taps_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sof   = out_sof_q;
    assign bus.out_eof   = out_eof_q;
    assign bus.taps      = taps_q;
    assign bus.out_row   = out_row_q;
    assign bus.out_col   = out_col_q;

endmodule

// File: tb/tb_fea_window_buffer.sv
// tb/tb_fea_window_buffer.sv - scoreboard bench for fea_window_buffer, both border modes
module tb_fea_window_buffer;
    localparam int WIDTH = 8;
    localparam int LINES = 3;
    localparam int COL   = 4;
    localparam int ROW   = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             sof = 1'b0;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int last_tag = 0;

    typedef struct {
        int          row;
        int          col;
        logic [23:0] taps;
        logic        sof;
        logic        eof;
        int          cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q0[$];

    fea_window_buffer_if #(.WIDTH(WIDTH), .LINES(LINES), .COL(COL), .ROW(ROW)) bus1 ();
    fea_window_buffer_if #(.WIDTH(WIDTH), .LINES(LINES), .COL(COL), .ROW(ROW)) bus0 ();

    assign bus1.in_valid = in_valid;
    assign bus1.din      = din;
    assign bus1.sof      = sof;
    assign bus0.in_valid = in_valid;
    assign bus0.din      = din;
    assign bus0.sof      = sof;

    fea_window_buffer #(.WIDTH(WIDTH), .LINES(LINES), .COL(COL), .ROW(ROW), .BORDER(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    fea_window_buffer #(.WIDTH(WIDTH), .LINES(LINES), .COL(COL), .ROW(ROW), .BORDER(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [WIDTH-1:0] pix(input int r, input int c);
        return WIDTH'(r * 16 + c);
    endfunction

    function automatic logic [23:0] model_taps(input int cr, input int cc, input bit border);
        logic [23:0] t;
        t = '0;
        for (int i = 0; i < LINES; i++) begin
            int tr;
            tr = cr - 1 + i;
            if (tr < 0)
                t[i*8 +: 8] = border ? pix(0, cc) : 8'h00;
            else if (tr > ROW - 1)
                t[i*8 +: 8] = border ? pix(ROW - 1, cc) : 8'h00;
            else
                t[i*8 +: 8] = pix(tr, cc);
        end
        return t;
    endfunction

    task automatic push_win(input int cr, input int cc, input int tag);
        exp_t e;
        e.row  = cr;
        e.col  = cc;
        e.sof  = (cr == 0 && cc == 0);
        e.eof  = (cr == ROW - 1 && cc == COL - 1);
        e.cyc  = tag + 2;
        e.taps = model_taps(cr, cc, 1'b1);
        q1.push_back(e);
        e.taps = model_taps(cr, cc, 1'b0);
        q0.push_back(e);
    endtask

    task automatic compare_win(input string name, input exp_t e, input int r, input int c,
                               input logic [23:0] t, input logic s, input logic eo);
        checks++;
        if (r != e.row || c != e.col || t !== e.taps || s !== e.sof || eo !== e.eof || cyc != e.cyc) begin
            errors++;
            $display("FAIL %s_window actual row=%0d col=%0d taps=%06h sof=%0b eof=%0b cyc=%0d required row=%0d col=%0d taps=%06h sof=%0b eof=%0b cyc=%0d",
                     name, r, c, t, s, eo, cyc, e.row, e.col, e.taps, e.sof, e.eof, e.cyc);
        end
    endtask

    always @(negedge clk) begin : mon1
        exp_t e;
        if (bus1.out_valid === 1'b1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b1_extra_window actual row=%0d col=%0d required no window", bus1.out_row, bus1.out_col);
            end else begin
                e = q1.pop_front();
                compare_win("b1", e, int'(bus1.out_row), int'(bus1.out_col), bus1.taps, bus1.out_sof, bus1.out_eof);
            end
            if (bus1.out_row == 2'd0 && bus1.out_col == 2'd1) chk("b1_taps_r0c1", bus1.taps, 24'h110101);
            if (bus1.out_row == 2'd3 && bus1.out_col == 2'd3) begin
                chk("b1_taps_r3c3", bus1.taps, 24'h333323);
                chk("b1_eof_r3c3", bus1.out_eof, 1);
            end
        end
    end

    always @(negedge clk) begin : mon0
        exp_t e;
        if (bus0.out_valid === 1'b1) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b0_extra_window actual row=%0d col=%0d required no window", bus0.out_row, bus0.out_col);
            end else begin
                e = q0.pop_front();
                compare_win("b0", e, int'(bus0.out_row), int'(bus0.out_col), bus0.taps, bus0.out_sof, bus0.out_eof);
            end
            if (bus0.out_row == 2'd0 && bus0.out_col == 2'd1) chk("b0_taps_r0c1", bus0.taps, 24'h110100);
            if (bus0.out_row == 2'd3 && bus0.out_col == 2'd2) chk("b0_taps_r3c2", bus0.taps, 24'h003222);
        end
    end

    // Called at a falling edge; returns at the falling edge after the accept.
    task automatic send_px(input int r, input int c, input bit bubbles);
        int guard;
        if (bubbles) begin
            repeat ($urandom_range(1, 0)) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
        end
        in_valid = 1'b1;
        din      = pix(r, c);
        sof      = (r == 0 && c == 0);
        guard    = 0;
        while (bus1.in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual in_ready=%0b required 1 at row=%0d col=%0d", bus1.in_ready, r, c);
        end
        last_tag = cyc;
        if (r >= 1) push_win(r - 1, c, cyc);
        @(negedge clk);
        in_valid = 1'b0;
        sof      = 1'b0;
    endtask

    task automatic send_frame(input bit bubbles, input bit rst_in_flush);
        int n;
        for (int r = 0; r < ROW; r++)
            for (int c = 0; c < COL; c++)
                send_px(r, c, bubbles);
        if (!rst_in_flush) begin
            for (int k = 0; k < COL; k++) push_win(ROW - 1, k, last_tag + 1 + k);
            n = 0;
            while (bus1.in_ready !== 1'b1 && n < 20) begin
                n++;
                @(negedge clk);
            end
            chk("flush_ready_low_cycles", n, COL);
        end else begin
            #2 rst = 1'b1;
            #1;
            chk("rst_flush_out_valid_b1", bus1.out_valid, 0);
            chk("rst_flush_out_valid_b0", bus0.out_valid, 0);
            chk("rst_flush_in_ready", bus1.in_ready, 0);
            q1.delete();
            q0.delete();
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            chk("rst_flush_ready_after", bus1.in_ready, 1);
            chk("rst_flush_no_window", bus1.out_valid, 0);
        end
    endtask

    initial begin
        int g;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", bus1.out_valid, 0);
        chk("rst_out_sof", bus1.out_sof, 0);
        chk("rst_out_eof", bus1.out_eof, 0);
        chk("rst_taps", bus1.taps, 0);
        chk("rst_out_row", bus1.out_row, 0);
        chk("rst_out_col", bus1.out_col, 0);
        chk("rst_in_ready", bus1.in_ready, 0);
        chk("rst_b0_taps", bus0.taps, 0);
        rst = 1'b0;
        #1;
        chk("in_ready_at_release", bus1.in_ready, 0);
        @(negedge clk);
        chk("in_ready_after_release", bus1.in_ready, 1);

        send_frame(1'b0, 1'b0);
        send_frame(1'b1, 1'b0);
        for (int i = 0; i < 9; i++) send_px(i / COL, i % COL, 1'b0);
        send_frame(1'b0, 1'b0);
        send_frame(1'b0, 1'b1);
        send_frame(1'b0, 1'b0);

        g = 0;
        while ((q1.size() != 0 || q0.size() != 0) && g < 30) begin
            @(negedge clk);
            #1;
            g++;
        end
        chk("b1_queue_drained", q1.size(), 0);
        chk("b0_queue_drained", q0.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
